stdmacro_rrarb_slice: RTL and testbench
=======================================

Name: stdmacro_rrarb_slice

Overview:
- N-input round-robin arbiter with a one-entry registered output slot (register slice).
- Shares one downstream valid/ready channel between NUM_REQ requesters. Typical use: a shared write-back or request bus.
- Full throughput: one transfer per cycle when downstream is always ready.
- Fixed one-cycle latency from accept to out_valid.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per requester.
- SRC_WIDTH, 2, width of source index; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- aresetn  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  output slot holds data.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  registered payload.
- out_src  output  SRC_WIDTH  registered index of the winning requester.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0.
  - All state registers reset asynchronously; no state change on the first edge after release unless inputs demand it.
- Load enable: load = ~out_valid | out_ready.
- Grant (combinational):
  - Scan req_valid starting at index ptr, ascending with wrap modulo NUM_REQ; the first set bit wins.
  - gnt is one-hot, or zero if no request is valid.
- req_ready[i] = load & gnt[i].
- req_ready must not depend on req_valid[i] of the same requester beyond grant selection, and must not depend on out_data.
- Transfer from requester i: req_valid[i] & req_ready[i]. On that edge:
  - out_data <= payload i; out_src <= i; out_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ; ptr=NUM_REQ-1 wraps to 0.
- Drain without refill (out_ready & out_valid, no transfer): out_valid <= 0; out_data and out_src hold their last values.
- Simultaneous drain and refill: out_valid stays 1 and new data is loaded in the same cycle; no bubble.
- Stall (out_valid & ~out_ready):
  - All req_ready=0; slot contents hold stable.
  - ptr holds; no starvation credit is lost.
- No valid request: ptr holds; gnt=0.
- Fairness: any requester held valid is granted within NUM_REQ transfers.
- Requesters may drop req_valid before being granted. The arbiter does not require valid-stickiness, but a dropped request forfeits its turn.
- Async reset asserted mid-transfer: slot cleared immediately; the in-flight payload is discarded.
- out_valid must never depend combinationally on out_ready.

Decomposition:
- Shared include header: constant function for clog2, and a parameter-legality check. The check fails elaboration if SRC_WIDTH < clog2(NUM_REQ) or NUM_REQ < 2.
- Sub-module stdmacro_rrarb_pick: purely combinational rotating priority picker.
  - Inputs: req, ptr. Outputs: one-hot gnt, binary gnt_idx, any.
  - Implementation: double-width masked priority encode.
- Top level holds:
  - ptr register and slot registers (out_valid, out_data, out_src).
  - All registers instantiated as std_dffran cells.
  - Enable realised by a d-side mux.

Test Plan:
- Reset: hold aresetn=0 with all req_valid=1 -> out_valid=0, out_data=0, out_src=0, req_ready=0 while reset is low. First grant after release goes to requester 0.
- Full contention, NUM_REQ=4, all req_valid=1, out_ready=1 constantly -> out_src sequence 0,1,2,3,0,1… with out_valid=1 every cycle from cycle 1.
- Back-pressure: slot full, out_ready=0 for 5 cycles with req_valid=4'b1010 -> req_ready=0 and out_data/out_src stable. After out_ready=1, the next granted source is (last_src+1) scanning, e.g. last=1 -> 3.
- Sparse requests: only req 2 valid with data 0xA5A5_0002, out_ready=1 -> out_data=0xA5A5_0002, out_src=2 one cycle later; ptr=3. Then only req 1 valid -> wrap search grants 1.
- Wrap at ptr=3: req_valid=4'b1001 after a grant to 2 -> grant 3, then grant 0.
- Mid-operation reset: assert aresetn=0 while out_valid=1 and the stall pattern is active -> out_valid drops asynchronously, before the next edge. After release the pointer restarts at 0.

Source files
------------

// File: rtl/stdmacro_rrarb_slice_pkg.sv
// Shared constants and elaboration-time helpers for the round-robin arbiter slice.
package stdmacro_rrarb_slice_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SRC_WIDTH  = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    // The source index must be able to name every requester.
    function automatic bit params_ok(input int num_req, input int src_width);
        return (num_req >= 2) && (num_req <= 16) && (src_width >= clog2(num_req));
    endfunction

endpackage

// File: rtl/std_dffran.sv
// Register cell with asynchronous active-low reset to a parameterised value.
module std_dffran #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/stdmacro_rrarb_slice_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to index 0.
module stdmacro_rrarb_pick #(
    parameter int NUM_REQ   = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SRC_WIDTH-1:0] gnt_idx,
    output logic                 any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    int                   sel;

    // Upper copy supplies the wrapped-around candidates below ptr.
    assign dbl = {req, req};

    generate
        for (genvar gi = 0; gi < 2*NUM_REQ; gi++) begin : g_mask
            assign masked[gi] = dbl[gi] & (gi >= int'(ptr));
        end
    endgenerate

    always_comb begin
        sel = 0;
        for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
            if (masked[j]) begin
                sel = j;
            end
        end
    end

    assign any     = |req;
    assign gnt_idx = (sel >= NUM_REQ) ? SRC_WIDTH'(sel - NUM_REQ) : SRC_WIDTH'(sel);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = any & (gnt_idx == SRC_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/stdmacro_rrarb_slice.sv
// N-input round-robin arbiter feeding a one-entry registered output slot.
module stdmacro_rrarb_slice
    import stdmacro_rrarb_slice_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SRC_WIDTH  = DEF_SRC_WIDTH
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src
);

    generate
        if (!params_ok(NUM_REQ, SRC_WIDTH)) begin : g_param_check
            $error("stdmacro_rrarb_slice: illegal NUM_REQ/SRC_WIDTH combination");
        end
    endgenerate

    logic [SRC_WIDTH-1:0]  ptr_reg, ptr_next;
    logic                  valid_reg, valid_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [SRC_WIDTH-1:0]  src_reg, src_next;

    logic [NUM_REQ-1:0]    gnt;
    logic [SRC_WIDTH-1:0]  gnt_idx;
    logic [SRC_WIDTH-1:0]  next_idx;
    logic                  any;
    logic                  load;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] payload [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_data;

    stdmacro_rrarb_pick #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Reset gates load so no requester sees ready while the slot is held cleared.
    assign load      = aresetn & (~valid_reg | out_ready);
    assign xfer      = load & any;
    assign req_ready = gnt & {NUM_REQ{load}};

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
            assign payload[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | (payload[i] & {DATA_WIDTH{gnt[i]}});
        end
    end

    assign next_idx = (gnt_idx == SRC_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        valid_next = load ? any : valid_reg;
        data_next  = xfer ? sel_data : data_reg;
        src_next   = xfer ? gnt_idx : src_reg;
        ptr_next   = xfer ? next_idx : ptr_reg;
    end

    std_dffran #(.WIDTH(SRC_WIDTH)) u_ptr (
        .clk(clk), .aresetn(aresetn), .d(ptr_next), .q(ptr_reg)
    );
    std_dffran #(.WIDTH(1)) u_valid (
        .clk(clk), .aresetn(aresetn), .d(valid_next), .q(valid_reg)
    );
    std_dffran #(.WIDTH(DATA_WIDTH)) u_data (
        .clk(clk), .aresetn(aresetn), .d(data_next), .q(data_reg)
    );
    std_dffran #(.WIDTH(SRC_WIDTH)) u_src (
        .clk(clk), .aresetn(aresetn), .d(src_next), .q(src_reg)
    );

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_src   = src_reg;

endmodule

// File: tb/tb_stdmacro_rrarb_slice.sv
// Randomised and directed bench for stdmacro_rrarb_slice with a queue-based scoreboard.
module tb_stdmacro_rrarb_slice;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;

    stdmacro_rrarb_slice #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: slot contents, rotating pointer, and in-order expected outputs.
    bit            m_full = 1'b0;
    int            m_ptr = 0;
    logic [DW-1:0] m_data = '0;
    int            m_src = 0;
    logic [DW+7:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic [N-1:0] v, input logic ordy, input bit pat);
        logic [DW-1:0] pay [N];
        int            win;
        bit            load;
        logic [N-1:0]  exp_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            pay[i] = pat ? (32'hA5A5_0000 | DW'(i)) : DW'($urandom);
            req_data[i*DW +: DW] = pay[i];
        end
        req_valid = v;
        out_ready = ordy;
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(m_full));
        if (m_full) begin
            check("slot_data", 64'(out_data), 64'(m_data));
            check("slot_src", 64'(out_src), 64'(m_src));
        end
        load = !m_full || ordy;
        win = -1;
        if (load) begin
            for (int k = N-1; k >= 0; k--) begin
                if (v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        exp_rdy = (win >= 0) ? N'(1 << win) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (win >= 0) begin
            m_full = 1'b1;
            m_data = pay[win];
            m_src  = win;
            m_ptr  = (win + 1) % N;
            sb.push_back({m_data, 8'(win)});
            $display("xfer src=%0d data=%08h ptr_next=%0d", win, m_data, m_ptr);
        end else if (load) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: every downstream handshake retires the oldest expected transfer.
    always @(negedge clk) begin
        logic [DW+7:0] e;
        if (aresetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_underflow: got out_src=%0d with no expected transfer", out_src);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e[DW+7:8]));
                check("out_src", 64'(out_src), 64'(e[7:0]));
                $display("drain src=%0d data=%08h", out_src, out_data);
            end
        end
    end

    initial begin
        // Reset held with all requesters asserting.
        req_valid = '1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        aresetn = 1'b1;

        // Full contention: grants rotate 0,1,2,3,...
        repeat (8) drive_cycle(4'b1111, 1'b1, 1'b0);

        // Back-pressure after a grant to 1; next grant must be 3.
        drive_cycle(4'b0010, 1'b1, 1'b0);
        repeat (5) drive_cycle(4'b1010, 1'b0, 1'b0);
        drive_cycle(4'b1010, 1'b1, 1'b0);

        // Sparse requests and wrap-around.
        drive_cycle(4'b0100, 1'b1, 1'b1);
        drive_cycle(4'b0010, 1'b1, 1'b1);
        drive_cycle(4'b0100, 1'b1, 1'b1);
        drive_cycle(4'b1001, 1'b1, 1'b1);
        drive_cycle(4'b1001, 1'b1, 1'b1);

        // Random traffic with intermittent back-pressure.
        for (int c = 0; c < 300; c++) begin
            drive_cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Mid-operation reset during a stall.
        drive_cycle(4'b1010, 1'b1, 1'b0);
        drive_cycle(4'b1010, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_req_ready", 64'(req_ready), 64'd0);
        m_full = 1'b0;
        m_ptr  = 0;
        m_src  = 0;
        sb.delete();
        req_valid = '0;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (5) drive_cycle(4'b1111, 1'b1, 1'b0);

        // Drain.
        repeat (3) drive_cycle(4'b0000, 1'b1, 1'b0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
